voice_scheduler: RTL

- Owns the synth's polyphonic voice bank.
- Accepts note-on and note-off events from the keyboard front end through a valid/ready handshake.
- Allocates a voice to each note, stealing one when all voices are busy.
- Runs a per-voice attack/sustain/release envelope, and drives the per-voice frequency and volume words consumed by the oscillator/mixer datapath.

---
 rtl/voice_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/voice_scheduler.sv
// voice_scheduler: polyphonic voice allocator with per-voice attack/sustain/release envelopes.
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   note_valid / note_ready   event handshake (ready only while the control FSM is idle)
//   note_on, note_num         press(1)/release(0) and note index 0..31
//   note_freq                 Q12.20 frequency, used for presses only
//   frequencies               per-voice frequency words
//   voice_volumes             per-voice Q.20 volume words
//   voice_active              per-voice envelope state != OFF
module voice_scheduler #(
   parameter int unsigned NUM_VOICES   = 8,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned FULL_VOL     = 32'h0010_0000,
   parameter int unsigned ATTACK_STEP  = 32'h0001_0000,
   parameter int unsigned RELEASE_STEP = 32'h0000_8000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        note_valid,
   output logic                        note_ready,
   input  logic                        note_on,
   input  logic [4:0]                  note_num,
   input  logic [31:0]                 note_freq,
   output logic [NUM_VOICES-1:0][31:0] frequencies,
   output logic [NUM_VOICES-1:0][31:0] voice_volumes,
   output logic [NUM_VOICES-1:0]       voice_active
);
   localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned VW = 32;
   localparam int unsigned SW = VW + 1;
   localparam int unsigned NW = 5;

   typedef enum logic [1:0] {CTL_IDLE, CTL_SCAN, CTL_COMMIT} ctl_t;
   typedef enum logic [1:0] {ENV_OFF, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE} env_t;
   typedef struct packed {
      logic          on;
      logic [NW-1:0] num;
      logic [VW-1:0] freq;
   } note_ev_t;

   ctl_t                          ctl_q, ctl_d;
   logic [IW-1:0]                 scan_q, scan_d;
   logic                          accept_c;
   note_ev_t                      ev_q;
   logic [TW-1:0]                 tick_q;
   logic                          tick_c;
   env_t                          env_q [NUM_VOICES];
   env_t                          env_d [NUM_VOICES];
   logic [NW-1:0]                 note_q [NUM_VOICES];
   logic [NW-1:0]                 note_d [NUM_VOICES];
   logic [NUM_VOICES-1:0][VW-1:0] freq_d, vol_d;
   logic [IW-1:0]                 ptr_q, ptr_d;
   logic                          rt_hit_q, rt_hit_d, off_hit_q, off_hit_d, rel_hit_q, rel_hit_d;
   logic [IW-1:0]                 rt_idx_q, rt_idx_d, off_idx_q, off_idx_d, rel_idx_q, rel_idx_d;
   logic [VW-1:0]                 rel_vol_q, rel_vol_d;
   logic [IW-1:0]                 sel_c;
   logic                          steal_c;
   logic [SW-1:0]                 sum_c;

   // Envelope tick pulse: one cycle every TICK_DIV clocks.
   assign tick_c = (tick_q == TW'(TICK_DIV - 1));

   // Control FSM next state: IDLE -> SCAN (one voice per cycle) -> COMMIT -> IDLE.
   always_comb begin
      ctl_d    = ctl_q;
      scan_d   = scan_q;
      accept_c = 1'b0;
      case (ctl_q)
         CTL_IDLE: begin
            if (note_valid && note_ready) begin
               accept_c = 1'b1;
               ctl_d    = CTL_SCAN;
               scan_d   = '0;
            end
         end
         CTL_SCAN: begin
            if (scan_q == IW'(NUM_VOICES - 1)) ctl_d = CTL_COMMIT;
            else                               scan_d = scan_q + IW'(1);
         end
         CTL_COMMIT: ctl_d = CTL_IDLE;
         default:    ctl_d = CTL_IDLE;
      endcase
   end

   // Note-on victim: retrigger, else first free, else quietest release, else round-robin steal.
   always_comb begin
      sel_c   = ptr_q;
      steal_c = 1'b0;
      if (rt_hit_q)       sel_c = rt_idx_q;
      else if (off_hit_q) sel_c = off_idx_q;
      else if (rel_hit_q) sel_c = rel_idx_q;
      else                steal_c = 1'b1;
   end

   // Voice bank next state: candidate recording, envelope tick, then commit overrides the tick.
   always_comb begin
      ptr_d     = ptr_q;
      rt_hit_d  = rt_hit_q;
      rt_idx_d  = rt_idx_q;
      off_hit_d = off_hit_q;
      off_idx_d = off_idx_q;
      rel_hit_d = rel_hit_q;
      rel_idx_d = rel_idx_q;
      rel_vol_d = rel_vol_q;
      sum_c     = '0;
      freq_d    = frequencies;
      vol_d     = voice_volumes;
      for (int i = 0; i < NUM_VOICES; i++) begin
         env_d[i]  = env_q[i];
         note_d[i] = note_q[i];
      end

      if (ctl_q == CTL_IDLE) begin
         rt_hit_d  = 1'b0;
         off_hit_d = 1'b0;
         rel_hit_d = 1'b0;
      end else if (ctl_q == CTL_SCAN) begin
         if (!rt_hit_q && env_q[scan_q] != ENV_OFF && note_q[scan_q] == ev_q.num) begin
            rt_hit_d = 1'b1;
            rt_idx_d = scan_q;
         end
         if (!off_hit_q && env_q[scan_q] == ENV_OFF) begin
            off_hit_d = 1'b1;
            off_idx_d = scan_q;
         end
         // Strict less-than keeps the lowest index on equal volumes.
         if (env_q[scan_q] == ENV_RELEASE && (!rel_hit_q || voice_volumes[scan_q] < rel_vol_q)) begin
            rel_hit_d = 1'b1;
            rel_idx_d = scan_q;
            rel_vol_d = voice_volumes[scan_q];
         end
      end

      if (tick_c) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            case (env_q[i])
               ENV_ATTACK: begin
                  sum_c = {1'b0, voice_volumes[i]} + SW'(ATTACK_STEP);
                  if (sum_c >= SW'(FULL_VOL)) begin
                     vol_d[i] = VW'(FULL_VOL);
                     env_d[i] = ENV_SUSTAIN;
                  end else begin
                     vol_d[i] = sum_c[VW-1:0];
                  end
               end
               ENV_RELEASE: begin
                  if (voice_volumes[i] <= VW'(RELEASE_STEP)) begin
                     vol_d[i] = '0;
                     env_d[i] = ENV_OFF;
                  end else begin
                     vol_d[i] = voice_volumes[i] - VW'(RELEASE_STEP);
                  end
               end
               ENV_OFF: vol_d[i] = '0;
               default: ;
            endcase
         end
      end

      if (ctl_q == CTL_COMMIT) begin
         if (ev_q.on) begin
            env_d[sel_c]  = ENV_ATTACK;
            vol_d[sel_c]  = steal_c ? '0 : voice_volumes[sel_c];
            freq_d[sel_c] = ev_q.freq;
            note_d[sel_c] = ev_q.num;
            if (steal_c) ptr_d = (ptr_q == IW'(NUM_VOICES - 1)) ? '0 : ptr_q + IW'(1);
         end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (note_q[i] == ev_q.num && (env_q[i] == ENV_ATTACK || env_q[i] == ENV_SUSTAIN)) begin
                  env_d[i] = ENV_RELEASE;
                  vol_d[i] = voice_volumes[i];
               end
            end
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctl_q      <= CTL_IDLE;
         scan_q     <= '0;
         ev_q       <= '0;
         note_ready <= 1'b0;
      end else begin
         ctl_q      <= ctl_d;
         scan_q     <= scan_d;
         note_ready <= (ctl_d == CTL_IDLE);
         if (accept_c) ev_q <= {note_on, note_num, note_freq};
      end
   end

   // Voice bank, candidate and tick registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q        <= '0;
         ptr_q         <= '0;
         rt_hit_q      <= 1'b0;
         rt_idx_q      <= '0;
         off_hit_q     <= 1'b0;
         off_idx_q     <= '0;
         rel_hit_q     <= 1'b0;
         rel_idx_q     <= '0;
         rel_vol_q     <= '0;
         frequencies   <= '0;
         voice_volumes <= '0;
         voice_active  <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            env_q[i]  <= ENV_OFF;
            note_q[i] <= '0;
         end
      end else begin
         tick_q        <= tick_c ? '0 : tick_q + TW'(1);
         ptr_q         <= ptr_d;
         rt_hit_q      <= rt_hit_d;
         rt_idx_q      <= rt_idx_d;
         off_hit_q     <= off_hit_d;
         off_idx_q     <= off_idx_d;
         rel_hit_q     <= rel_hit_d;
         rel_idx_q     <= rel_idx_d;
         rel_vol_q     <= rel_vol_d;
         frequencies   <= freq_d;
         voice_volumes <= vol_d;
         for (int i = 0; i < NUM_VOICES; i++) begin
            env_q[i]        <= env_d[i];
            note_q[i]       <= note_d[i];
            voice_active[i] <= (env_d[i] != ENV_OFF);
         end
      end
   end
endmodule
